output_arbiter: RTL and testbench

//  Per-output-port wormhole arbiter. It is the consumer of the one-hot port requests produced by the input routers.

---
 rtl/output_arbiter.sv | 154 +++++++++++++++
 tb/tb_output_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_arbiter.sv
// Per-output-port wormhole arbiter: round-robin over packet heads, grant held head->tail.
// Define OUT_BUFFER_EN for a 2-entry registered output FIFO; default build is a 0-latency pass-through.
module output_arbiter #(
   parameter int FLIT_WIDTH = 37,
   parameter int NUM_IN     = 5
) (
   input  logic                         clk,
   input  logic                         arst,
   input  logic [NUM_IN-1:0]            fin_valid_i,
   input  logic [NUM_IN-1:0]            fin_req_i,
   input  logic [NUM_IN*FLIT_WIDTH-1:0] fin_flit_i,
   output logic [NUM_IN-1:0]            fin_ready_o,
   output logic                         fout_valid_o,
   output logic [FLIT_WIDTH-1:0]        fout_flit_o,
   input  logic                         fout_ready_i,
   output logic [NUM_IN-1:0]            grant_o,
   output logic                         lock_o
);

   localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_LOCKED = 1'b1;

   localparam logic [1:0] T_HEAD   = 2'b00;
   localparam logic [1:0] T_TAIL   = 2'b10;
   localparam logic [1:0] T_SINGLE = 2'b11;

   logic [0:0]            r_state;
   logic [IDX_W-1:0]      r_ptr;
   logic [IDX_W-1:0]      r_gidx;

   logic [NUM_IN-1:0]     w_cand;
   logic                  w_selFound;
   logic [IDX_W-1:0]      w_selIdx;
   logic [IDX_W-1:0]      w_gidx;
   logic                  w_active;
   logic [FLIT_WIDTH-1:0] w_inFlit;
   logic                  w_inValid;
   logic [1:0]            w_inType;
   logic                  w_linkReady;
   logic                  w_xfer;
   logic [NUM_IN-1:0]     w_gidxOneHot;

   // Only heads (single or multi-flit) may start a packet; stale body/tail flits never win.
   always_comb begin
      w_cand = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         w_cand[k] = fin_valid_i[k] & fin_req_i[k] &
                     ((fin_flit_i[k*FLIT_WIDTH+FLIT_WIDTH-2 +: 2] == T_HEAD) ||
                      (fin_flit_i[k*FLIT_WIDTH+FLIT_WIDTH-2 +: 2] == T_SINGLE));
      end
   end

   always_comb begin
      logic [IDX_W-1:0] idx;
      w_selFound = 1'b0;
      w_selIdx   = '0;
      idx        = '0;
      for (int i = 1; i <= NUM_IN; i++) begin
         idx = IDX_W'((int'(r_ptr) + i) % NUM_IN);
         if (!w_selFound && w_cand[idx]) begin
            w_selFound = 1'b1;
            w_selIdx   = idx;
         end
      end
   end

   // Reset gates the whole datapath so nothing leaks out while arst is held low.
   assign w_gidx       = (r_state == S_LOCKED) ? r_gidx : w_selIdx;
   assign w_active     = arst & ((r_state == S_LOCKED) | w_selFound);
   assign w_gidxOneHot = {{(NUM_IN-1){1'b0}}, 1'b1} << w_gidx;
   assign grant_o      = w_active ? w_gidxOneHot : '0;
   assign lock_o       = (r_state == S_LOCKED);

   always_comb begin
      w_inFlit = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (IDX_W'(k) == w_gidx) begin
            w_inFlit = fin_flit_i[k*FLIT_WIDTH +: FLIT_WIDTH];
         end
      end
   end

   assign w_inValid   = w_active & fin_valid_i[w_gidx] & fin_req_i[w_gidx];
   assign w_inType    = w_inFlit[FLIT_WIDTH-1:FLIT_WIDTH-2];
   assign fin_ready_o = (w_active && w_linkReady) ? w_gidxOneHot : '0;

`ifdef OUT_BUFFER_EN
   logic [FLIT_WIDTH-1:0] r_fifo [2];
   logic                  r_wrPtr;
   logic                  r_rdPtr;
   logic [1:0]            r_count;
   logic                  w_full;
   logic                  w_push;
   logic                  w_pop;

   assign w_full       = (r_count == 2'd2);
   assign w_push       = w_inValid & ~w_full;
   assign w_pop        = (r_count != 2'd0) & fout_ready_i;
   assign w_linkReady  = ~w_full;
   assign w_xfer       = w_push;
   assign fout_valid_o = (r_count != 2'd0);
   assign fout_flit_o  = r_fifo[r_rdPtr];

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         r_fifo[0] <= '0;
         r_fifo[1] <= '0;
         r_wrPtr   <= 1'b0;
         r_rdPtr   <= 1'b0;
         r_count   <= 2'd0;
      end else begin
         if (w_push) begin
            r_fifo[r_wrPtr] <= w_inFlit;
            r_wrPtr         <= ~r_wrPtr;
         end
         if (w_pop) begin
            r_rdPtr <= ~r_rdPtr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end
`else
   assign w_linkReady  = fout_ready_i;
   assign w_xfer       = w_inValid & fout_ready_i;
   assign fout_valid_o = w_inValid;
   assign fout_flit_o  = w_inFlit;
`endif

   // A head arriving while locked is forwarded unchanged; only a tail releases the lock.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         r_state <= S_IDLE;
         r_ptr   <= IDX_W'(NUM_IN-1);
         r_gidx  <= '0;
      end else if (w_xfer) begin
         if (r_state == S_IDLE) begin
            r_ptr  <= w_gidx;
            r_gidx <= w_gidx;
            if (w_inType == T_HEAD) begin
               r_state <= S_LOCKED;
            end
         end else if (w_inType == T_TAIL) begin
            r_state <= S_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_output_arbiter.sv
// Directed self-checking bench for output_arbiter; per-input flit queues drive the DUT and a
// monitor captures every accepted output flit for in-order comparison.
module tb_output_arbiter;

   localparam int FW = 37;
   localparam int NI = 5;

   logic             clk = 1'b0;
   logic             arst;
   logic [NI-1:0]    finValid;
   logic [NI-1:0]    finReq;
   logic [NI*FW-1:0] finFlit;
   logic [NI-1:0]    finReady;
   logic             foutValid;
   logic [FW-1:0]    foutFlit;
   logic             foutReady;
   logic [NI-1:0]    grant;
   logic             lock;

   logic [FW-1:0]    srcMem [NI][128];
   int               srcWr [NI];
   int               srcRd [NI];
   logic [FW-1:0]    outMem [512];
   int               outCnt;
   int               nAsserts;
   int               nFail;
   int               base;
   logic [FW-1:0]    expFlit;
   logic [FW-1:0]    heldFlit;
   logic [1:0]       pktTypes [4];

   output_arbiter #(.FLIT_WIDTH(FW), .NUM_IN(NI)) dut (
      .clk          (clk),
      .arst         (arst),
      .fin_valid_i  (finValid),
      .fin_req_i    (finReq),
      .fin_flit_i   (finFlit),
      .fin_ready_o  (finReady),
      .fout_valid_o (foutValid),
      .fout_flit_o  (foutFlit),
      .fout_ready_i (foutReady),
      .grant_o      (grant),
      .lock_o       (lock)
   );

   // Free-running clock; inputs change just after rising edges, sampling happens on falling edges.
   always #5 clk = ~clk;

   // Hard stop in case something upstream of the bounded waits goes wrong.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [FW-1:0] mkFlit(input logic [1:0] t, input int src, input int seq);
      return {t, 3'(src), 32'(seq)};
   endfunction

   task automatic refresh();
      for (int k = 0; k < NI; k++) begin
         finValid[k] = (srcRd[k] < srcWr[k]);
         finReq[k]   = finValid[k];
         finFlit[k*FW +: FW] = finValid[k] ? srcMem[k][srcRd[k]] : '0;
      end
   endtask

   task automatic applyStimulus(input int k, input logic [FW-1:0] flit);
      srcMem[k][srcWr[k]] = flit;
      srcWr[k]++;
      refresh();
   endtask

   task automatic clearSources();
      for (int k = 0; k < NI; k++) srcRd[k] = srcWr[k];
      refresh();
   endtask

   task automatic step();
      logic [NI-1:0] xfer;
      @(negedge clk);
      xfer = finValid & finReq & finReady;
      if (foutValid && foutReady) begin
         outMem[outCnt] = foutFlit;
         outCnt++;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
         if (xfer[k]) srcRd[k]++;
      end
      refresh();
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic waitOut(input string tag, input int n);
      int budget;
      budget = 300;
      while (outCnt < n && budget > 0) begin
         step();
         budget--;
      end
      checkOutput(tag, 64'(outCnt), 64'(n));
   endtask

   task automatic resetDut();
      clearSources();
      arst = 1'b0;
      step();
      step();
      arst = 1'b1;
      #1;
   endtask

   initial begin
      arst      = 1'b0;
      foutReady = 1'b1;
      outCnt    = 0;
      nAsserts  = 0;
      nFail     = 0;
      for (int k = 0; k < NI; k++) begin
         srcWr[k] = 0;
         srcRd[k] = 0;
      end
      pktTypes[0] = 2'b00;
      pktTypes[1] = 2'b01;
      pktTypes[2] = 2'b01;
      pktTypes[3] = 2'b10;
      refresh();

      // T1: reset held with every input offering a single-flit packet
      for (int k = 0; k < NI; k++) applyStimulus(k, mkFlit(2'b11, k, 100));
      step();
      step();
      checkOutput("T1 reset fout_valid", 64'(foutValid), 64'd0);
      checkOutput("T1 reset grant", 64'(grant), 64'd0);
      checkOutput("T1 reset lock", 64'(lock), 64'd0);
      checkOutput("T1 reset fin_ready", 64'(finReady), 64'd0);
      arst = 1'b1;
      #1;
      checkOutput("T1 first grant", 64'(grant), 64'h01);
      checkOutput("T1 first fin_ready", 64'(finReady), 64'h01);
`ifdef OUT_BUFFER_EN
      checkOutput("T1 buffered fout_valid", 64'(foutValid), 64'd0);
`else
      checkOutput("T1 passthru fout_valid", 64'(foutValid), 64'd1);
`endif
      base = outCnt;
      waitOut("T1 drain", base + 5);
      for (int k = 0; k < NI; k++) begin
         checkOutput("T1 order", 64'(outMem[base+k]), 64'(mkFlit(2'b11, k, 100)));
      end

      // T2: single head+tail flit on input 2
      expFlit = {2'b11, 35'h1800000AB};
      applyStimulus(2, expFlit);
      #1;
      checkOutput("T2 grant", 64'(grant), 64'h04);
      checkOutput("T2 lock", 64'(lock), 64'd0);
`ifndef OUT_BUFFER_EN
      checkOutput("T2 zero-latency valid", 64'(foutValid), 64'd1);
      checkOutput("T2 zero-latency flit", 64'(foutFlit), 64'(expFlit));
`endif
      base = outCnt;
      step();
      checkOutput("T2 lock after", 64'(lock), 64'd0);
`ifdef OUT_BUFFER_EN
      checkOutput("T2 one-cycle valid", 64'(foutValid), 64'd1);
      checkOutput("T2 one-cycle flit", 64'(foutFlit), 64'(expFlit));
`endif
      waitOut("T2 drain", base + 1);
      checkOutput("T2 flit", 64'(outMem[base]), 64'(expFlit));

      // T3: two 4-flit packets compete; the first must finish before the second starts
      resetDut();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, mkFlit(pktTypes[i], 0, i));
         applyStimulus(3, mkFlit(pktTypes[i], 3, i));
      end
      #1;
      checkOutput("T3 grant idle", 64'(grant), 64'h01);
      checkOutput("T3 lock idle", 64'(lock), 64'd0);
      base = outCnt;
      step();
      checkOutput("T3 lock held", 64'(lock), 64'd1);
      checkOutput("T3 grant held", 64'(grant), 64'h01);
      waitOut("T3 drain", base + 8);
      for (int i = 0; i < 8; i++) begin
         checkOutput("T3 wormhole order", 64'(outMem[base+i]),
                     64'(mkFlit(pktTypes[i%4], (i < 4) ? 0 : 3, i % 4)));
      end
      checkOutput("T3 lock released", 64'(lock), 64'd0);
      checkOutput("T3 grant idle end", 64'(grant), 64'd0);

      // T4: three inputs streaming single-flit packets rotate 1,2,4
      resetDut();
      for (int j = 0; j < 10; j++) begin
         applyStimulus(1, mkFlit(2'b11, 1, j));
         applyStimulus(2, mkFlit(2'b11, 2, j));
         applyStimulus(4, mkFlit(2'b11, 4, j));
      end
      base = outCnt;
      waitOut("T4 drain", base + 30);
      for (int j = 0; j < 10; j++) begin
         checkOutput("T4 rr 1", 64'(outMem[base+3*j]),   64'(mkFlit(2'b11, 1, j)));
         checkOutput("T4 rr 2", 64'(outMem[base+3*j+1]), 64'(mkFlit(2'b11, 2, j)));
         checkOutput("T4 rr 4", 64'(outMem[base+3*j+2]), 64'(mkFlit(2'b11, 4, j)));
      end

      // T5: downstream stalls for 5 cycles after the head has been accepted
      resetDut();
      for (int i = 0; i < 4; i++) applyStimulus(0, mkFlit(pktTypes[i], 0, 10 + i));
      base = outCnt;
      step();
      foutReady = 1'b0;
      #1;
`ifdef OUT_BUFFER_EN
      heldFlit = mkFlit(2'b00, 0, 10);
`else
      heldFlit = mkFlit(2'b01, 0, 11);
`endif
      for (int c = 0; c < 5; c++) begin
         checkOutput("T5 stall valid", 64'(foutValid), 64'd1);
         checkOutput("T5 stall flit stable", 64'(foutFlit), 64'(heldFlit));
         step();
      end
      checkOutput("T5 stall fin_ready", 64'(finReady), 64'd0);
      checkOutput("T5 stall lock", 64'(lock), 64'd1);
`ifdef OUT_BUFFER_EN
      checkOutput("T5 stall outputs", 64'(outCnt - base), 64'd0);
`else
      checkOutput("T5 stall outputs", 64'(outCnt - base), 64'd1);
`endif
      foutReady = 1'b1;
      waitOut("T5 drain", base + 4);
      for (int i = 0; i < 4; i++) begin
         checkOutput("T5 order", 64'(outMem[base+i]), 64'(mkFlit(pktTypes[i], 0, 10 + i)));
      end

      // T6: reset lands after the first body flit; the leftover body must be ignored
      resetDut();
      for (int i = 0; i < 4; i++) applyStimulus(0, mkFlit(pktTypes[i], 0, 20 + i));
      step();
      step();
      checkOutput("T6 lock mid", 64'(lock), 64'd1);
      arst = 1'b0;
      #1;
      checkOutput("T6 lock cleared", 64'(lock), 64'd0);
      checkOutput("T6 grant cleared", 64'(grant), 64'd0);
      step();
      arst = 1'b1;
      #1;
      checkOutput("T6 stale grant", 64'(grant), 64'd0);
      checkOutput("T6 stale fin_ready", 64'(finReady), 64'd0);
      base = outCnt;
      step();
      step();
      step();
      checkOutput("T6 stale not forwarded", 64'(outCnt), 64'(base));
      clearSources();
      expFlit = mkFlit(2'b11, 3, 30);
      applyStimulus(3, expFlit);
      #1;
      checkOutput("T6 new grant", 64'(grant), 64'h08);
      waitOut("T6 drain", base + 1);
      checkOutput("T6 new flit", 64'(outMem[base]), 64'(expFlit));

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end

endmodule
